// File: rtl/rx_deser_frame.sv
// Pixel deserializer: strips start/stop framing from the recovered bit stream and emits
// row/column-tagged parallel pixels. Optional even parity per word via RX_DESER_PARITY_EN.
module rx_deser_frame #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned COLS  = 250,
    parameter int unsigned ROWS  = 250,
    parameter int unsigned COL_W = 8,
    parameter int unsigned ROW_W = 8
) (
    input  logic             SCLOCK,
    input  logic             RESET,
    input  logic             FRAME_SYNC_START,
    input  logic             SER_INPUT,
    input  logic             SER_INPUT_EN,
    output logic [PIX_W-1:0] PAR_DATA,
    output logic             PAR_DATA_EN,
    output logic [ROW_W-1:0] ROW_NUM,
    output logic [COL_W-1:0] COL_NUM,
    output logic             FRAME_DONE,
    output logic             FRAME_ACTIVE,
    output logic             ERROR,
    output logic             DEC_RSYNC
);

    localparam int unsigned CNT_W = $clog2(PIX_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PIX_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [PIX_W-1:0]   par_data_d;
    logic [ROW_W-1:0]   row_num_d;
    logic [COL_W-1:0]   col_num_d;
    logic               par_en_d;
    logic               done_d;
    logic               active_d;
    logic               err_d;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        par_data_d = PAR_DATA;
        row_num_d  = ROW_NUM;
        col_num_d  = COL_NUM;
        par_en_d   = 1'b0;
        done_d     = 1'b0;
        active_d   = FRAME_ACTIVE;
        err_d      = 1'b0;

        // A sync pulse restarts the frame from any state and swallows a coincident bit
        if (FRAME_SYNC_START) begin
            row_d     = '0;
            col_d     = '0;
            bit_cnt_d = '0;
            active_d  = 1'b1;
            state_d   = S_HUNT;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_HUNT: begin
                    if (SER_INPUT_EN && SER_INPUT) begin
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (SER_INPUT_EN) begin
                        shift_d   = {shift_q[PIX_W-2:0], SER_INPUT};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(PIX_W - 1)) begin
                            bit_cnt_d = '0;
`ifdef RX_DESER_PARITY_EN
                            state_d   = S_PARITY;
`else
                            state_d   = S_STOP;
`endif
                        end
                    end
                end
`ifdef RX_DESER_PARITY_EN
                S_PARITY: begin
                    if (SER_INPUT_EN) begin
                        if (SER_INPUT != (^shift_q)) begin
                            err_d    = 1'b1;
                            active_d = 1'b0;
                            state_d  = S_IDLE;
                        end else begin
                            state_d  = S_STOP;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (SER_INPUT_EN) begin
                        if (SER_INPUT) begin
                            err_d    = 1'b1;
                            active_d = 1'b0;
                            state_d  = S_IDLE;
                        end else begin
                            par_data_d = shift_q;
                            par_en_d   = 1'b1;
                            row_num_d  = row_q;
                            col_num_d  = col_q;
                            state_d    = S_HUNT;
                            if (col_q == COL_W'(COLS - 1)) begin
                                col_d = '0;
                                if (row_q == ROW_W'(ROWS - 1)) begin
                                    row_d   = '0;
                                    state_d = S_DONE;
                                end else begin
                                    row_d = row_q + ROW_W'(1);
                                end
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end
                    end
                end
                // Frame complete one cycle after the final pixel strobe
                S_DONE: begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge SCLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
            PAR_DATA     <= '0;
            PAR_DATA_EN  <= 1'b0;
            ROW_NUM      <= '0;
            COL_NUM      <= '0;
            FRAME_DONE   <= 1'b0;
            FRAME_ACTIVE <= 1'b0;
            ERROR        <= 1'b0;
            DEC_RSYNC    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            PAR_DATA     <= par_data_d;
            PAR_DATA_EN  <= par_en_d;
            ROW_NUM      <= row_num_d;
            COL_NUM      <= col_num_d;
            FRAME_DONE   <= done_d;
            FRAME_ACTIVE <= active_d;
            ERROR        <= err_d;
            DEC_RSYNC    <= err_d;
        end
    end

endmodule

// File: tb/tb_rx_deser_frame.sv
// Directed/randomized bench for rx_deser_frame with a word-level reference model
// (pixel index -> row/col, expected strobes, errors and frame completion).
module tb_rx_deser_frame;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned COLS  = 4;
    localparam int unsigned ROWS  = 3;
    localparam int unsigned COL_W = 2;
    localparam int unsigned ROW_W = 2;
    localparam int unsigned TOTAL = COLS * ROWS;

    localparam int M_GOOD    = 0;
    localparam int M_BADSTOP = 1;
    localparam int M_BADPAR  = 2;
    localparam int M_IGNORED = 3;

    logic             SCLOCK;
    logic             RESET;
    logic             FRAME_SYNC_START;
    logic             SER_INPUT;
    logic             SER_INPUT_EN;
    logic [PIX_W-1:0] PAR_DATA;
    logic             PAR_DATA_EN;
    logic [ROW_W-1:0] ROW_NUM;
    logic [COL_W-1:0] COL_NUM;
    logic             FRAME_DONE;
    logic             FRAME_ACTIVE;
    logic             ERROR;
    logic             DEC_RSYNC;

    int   vectors     = 0;
    int   miscompares = 0;
    int   idx         = 0;
    logic exp_active  = 1'b0;

    rx_deser_frame #(
        .PIX_W(PIX_W), .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)
    ) dut (
        .SCLOCK          (SCLOCK),
        .RESET           (RESET),
        .FRAME_SYNC_START(FRAME_SYNC_START),
        .SER_INPUT       (SER_INPUT),
        .SER_INPUT_EN    (SER_INPUT_EN),
        .PAR_DATA        (PAR_DATA),
        .PAR_DATA_EN     (PAR_DATA_EN),
        .ROW_NUM         (ROW_NUM),
        .COL_NUM         (COL_NUM),
        .FRAME_DONE      (FRAME_DONE),
        .FRAME_ACTIVE    (FRAME_ACTIVE),
        .ERROR           (ERROR),
        .DEC_RSYNC       (DEC_RSYNC)
    );

    initial SCLOCK = 1'b0;
    always #5 SCLOCK = ~SCLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, then the per-cycle strobe/status expectations
    task automatic tick(input logic sync, input logic en, input logic b,
                        input logic x_en, input logic x_err, input logic x_done);
        FRAME_SYNC_START = sync;
        SER_INPUT_EN     = en;
        SER_INPUT        = b;
        @(posedge SCLOCK);
        #1;
        if (sync) exp_active = 1'b1;
        else if (x_err || x_done) exp_active = 1'b0;
        chk("par_data_en",  32'(PAR_DATA_EN),  32'(x_en));
        chk("error",        32'(ERROR),        32'(x_err));
        chk("dec_rsync",    32'(DEC_RSYNC),    32'(x_err));
        chk("frame_done",   32'(FRAME_DONE),   32'(x_done));
        chk("frame_active", 32'(FRAME_ACTIVE), 32'(exp_active));
        FRAME_SYNC_START = 1'b0;
        SER_INPUT_EN     = 1'b0;
    endtask

    task automatic do_sync(input logic with_bit);
        tick(1'b1, with_bit, 1'b1, 1'b0, 1'b0, 1'b0);
        idx = 0;
    endtask

    task automatic gap(input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [PIX_W-1:0] v, input int mode, input int n_fill, input bit gaps);
        logic bits[$];
        logic last;
        bits = {};
        repeat (n_fill) bits.push_back(1'b0);
        bits.push_back(1'b1);
        for (int i = PIX_W - 1; i >= 0; i--) bits.push_back(v[i]);
`ifdef RX_DESER_PARITY_EN
        bits.push_back((^v) ^ (mode == M_BADPAR));
        if (mode != M_BADPAR) bits.push_back(mode == M_BADSTOP);
`else
        bits.push_back(mode == M_BADSTOP);
`endif
        for (int k = 0; k < bits.size(); k++) begin
            gap(gaps);
            last = (k == bits.size() - 1);
            tick(1'b0, 1'b1, bits[k], last && (mode == M_GOOD),
                 last && (mode == M_BADSTOP || mode == M_BADPAR), 1'b0);
        end
        if (mode == M_GOOD) begin
            chk("par_data", 32'(PAR_DATA), 32'(v));
            chk("row_num",  32'(ROW_NUM),  32'(idx / COLS));
            chk("col_num",  32'(COL_NUM),  32'(idx % COLS));
            idx++;
            if (idx == TOTAL) begin
                idx = 0;
                tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end
    endtask

    // Start bit plus the first n data bits of a word, no stop
    task automatic send_partial(input logic [PIX_W-1:0] v, input int n);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, v[PIX_W-1-i], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_par_data",     32'(PAR_DATA),     32'd0);
        chk("rst_par_data_en",  32'(PAR_DATA_EN),  32'd0);
        chk("rst_row_num",      32'(ROW_NUM),      32'd0);
        chk("rst_col_num",      32'(COL_NUM),      32'd0);
        chk("rst_frame_done",   32'(FRAME_DONE),   32'd0);
        chk("rst_frame_active", 32'(FRAME_ACTIVE), 32'd0);
        chk("rst_error",        32'(ERROR),        32'd0);
        chk("rst_dec_rsync",    32'(DEC_RSYNC),    32'd0);
    endtask

    initial begin
        RESET            = 1'b0;
        FRAME_SYNC_START = 1'b0;
        SER_INPUT        = 1'b0;
        SER_INPUT_EN     = 1'b0;
        repeat (2) @(posedge SCLOCK);
        #1;
        chk_reset_outputs();
        @(negedge SCLOCK);
        RESET = 1'b1;

        // Bits before any sync are ignored
        send_word(PIX_W'(8'h5A), M_IGNORED, 0, 1'b0);

        // Single word, back-to-back bits
        do_sync(1'b0);
        send_word(PIX_W'(8'hA5), M_GOOD, 0, 1'b0);

        // Full frame, values 0..11, random fill and enable gaps
        do_sync(1'b0);
        for (int p = 0; p < int'(TOTAL); p++)
            send_word(PIX_W'(p), M_GOOD, $urandom_range(0, 2), 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bad stop on word 2, then bits ignored until the next sync
        do_sync(1'b0);
        send_word(PIX_W'($urandom), M_GOOD, 1, 1'b1);
        send_word(PIX_W'($urandom), M_GOOD, 0, 1'b1);
        send_word(PIX_W'($urandom), M_BADSTOP, 0, 1'b1);
        send_word(PIX_W'($urandom), M_IGNORED, 1, 1'b1);

        // Mid-frame abort after 5 pixels, sync coincident with a valid 1 bit
        do_sync(1'b0);
        for (int p = 0; p < 5; p++) send_word(PIX_W'($urandom), M_GOOD, $urandom_range(0, 2), 1'b1);
        send_partial(PIX_W'(8'hFF), 3);
        do_sync(1'b1);
        send_word(PIX_W'(8'h3C), M_GOOD, 0, 1'b0);
        send_word(PIX_W'($urandom), M_GOOD, 1, 1'b1);

        // Asynchronous reset during the data bits of pixel 7
        do_sync(1'b0);
        for (int p = 0; p < 7; p++) send_word(PIX_W'($urandom | 1), M_GOOD, $urandom_range(0, 1), 1'b1);
        send_partial(PIX_W'(8'hC3), 4);
        #2;
        RESET = 1'b0;
        #1;
        chk_reset_outputs();
        exp_active = 1'b0;
        @(negedge SCLOCK);
        RESET = 1'b1;
        do_sync(1'b0);
        send_word(PIX_W'(8'h81), M_GOOD, 0, 1'b1);

`ifdef RX_DESER_PARITY_EN
        do_sync(1'b0);
        send_word(PIX_W'(8'h03), M_GOOD, 0, 1'b0);
        send_word(PIX_W'(8'h07), M_BADPAR, 0, 1'b0);
        send_word(PIX_W'(8'h11), M_IGNORED, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/rx_deser_frame.md
# rx_deser_frame

Parametrised pixel deserializer for the sensor receive path. Takes the oversampler's recovered bit stream (one bit per `SER_INPUT_EN` strobe) after a frame-sync pulse, strips per-word start/stop framing, and emits parallel pixels tagged with row/column position to the RAM controller. Successor to the fixed 8-bit, fixed-geometry deserializer: pixel width and frame geometry are generic, framing is checked, and frame completion and errors are reported explicitly.

## Interface
Parameters:
- `PIX_W`, 8: data bits per pixel word (4..16).
- `COLS`, 250: pixels per row.
- `ROWS`, 250: rows per frame.
- `COL_W`, 8: width of `COL_NUM`; must satisfy 2^COL_W ≥ COLS.
- `ROW_W`, 8: width of `ROW_NUM`; must satisfy 2^ROW_W ≥ ROWS.

Ports:
- `SCLOCK` in 1: sample clock; the only clock.
- `RESET` in 1: asynchronous, active-low reset.
- `FRAME_SYNC_START` in 1: single-cycle pulse marking the start of a frame's pixel stream.
- `SER_INPUT` in 1: recovered serial bit.
- `SER_INPUT_EN` in 1: `SER_INPUT` valid this cycle.
- `PAR_DATA` out PIX_W: assembled pixel, MSB first on the wire.
- `PAR_DATA_EN` out 1: one-cycle pixel valid strobe.
- `ROW_NUM` out ROW_W: row of the current `PAR_DATA`.
- `COL_NUM` out COL_W: column of the current `PAR_DATA`.
- `FRAME_DONE` out 1: one-cycle pulse after the last pixel of a frame.
- `FRAME_ACTIVE` out 1: high from accepted sync until done or error.
- `ERROR` out 1: one-cycle pulse on a framing violation.
- `DEC_RSYNC` out 1: one-cycle request to the sampler to resynchronise; coincident with `ERROR`.

## Operation
- Wire word format: start bit `1`, then PIX_W data bits MSB first, then stop bit `0`. Only cycles with `SER_INPUT_EN`=1 are consumed.
- States:
  - IDLE: waits for `FRAME_SYNC_START`. On the pulse, clears the row/column counters, sets `FRAME_ACTIVE`, and goes to HUNT.
  - HUNT: consumes bits until a `1` arrives, then goes to DATA with the bit counter at 0. `0` bits are idle filler and are ignored.
  - DATA: shifts PIX_W bits into the shift register (new bit at LSB). After the PIX_W-th bit, goes to STOP.
  - STOP: consumes one bit.
    - `0`: loads the shift register into `PAR_DATA`, pulses `PAR_DATA_EN`, advances the column counter, and returns to HUNT.
    - `1`: pulses `ERROR` and `DEC_RSYNC`, clears `FRAME_ACTIVE`, goes to IDLE. No pixel is emitted.
- Position counters:
  - `COL_NUM` and `ROW_NUM` hold the position of the pixel being emitted.
  - After emitting at col COLS-1, the column wraps to 0 and the row increments.
  - After emitting at (ROWS-1, COLS-1), pulse `FRAME_DONE` the next cycle, clear `FRAME_ACTIVE`, and go to IDLE. Counters wrap to 0.
- `FRAME_SYNC_START` in any non-IDLE state aborts the current frame:
  - Counters clear, the FSM goes to HUNT, and `FRAME_ACTIVE` stays high.
  - No `ERROR` and no `FRAME_DONE`.
- `FRAME_SYNC_START` and `SER_INPUT_EN` in the same cycle: sync wins and the bit is discarded.
- Bits arriving in IDLE are ignored.

## Timing
- Reset values: `PAR_DATA`=0, `PAR_DATA_EN`=0, `ROW_NUM`=0, `COL_NUM`=0, `FRAME_DONE`=0, `FRAME_ACTIVE`=0, `ERROR`=0, `DEC_RSYNC`=0. FSM in IDLE, shift register and bit counter at 0.
- Reset asserted mid-frame: immediate return to reset values. A partial word is dropped.
- `PAR_DATA_EN` rises the cycle after the stop-bit sample (1-cycle latency). `PAR_DATA`, `ROW_NUM` and `COL_NUM` are registered, stable with the strobe, and held until the next strobe.
- `FRAME_DONE` asserts the cycle after the final `PAR_DATA_EN`.
- `ERROR`/`DEC_RSYNC` assert the cycle after the offending stop-bit sample.
- `FRAME_ACTIVE` falls in the same cycle that `FRAME_DONE` or `ERROR` rises.
- Minimum spacing between `PAR_DATA_EN` pulses is PIX_W+2 enabled bits. There is no backpressure; the downstream sink must accept one pixel per strobe.
- `FRAME_SYNC_START` is accepted as a new frame in the cycle after `FRAME_DONE`.

## Configuration
- Macro `RX_DESER_PARITY_EN`.
- Defined:
  - Word format becomes start, PIX_W data bits, even-parity bit over the data, stop; the FSM gains a PARITY state between DATA and STOP.
  - A parity mismatch takes the same error path as a bad stop bit, evaluated when the parity bit is consumed. The stop bit is not consumed.
  - Minimum pixel spacing becomes PIX_W+3 enabled bits.
- Undefined: no parity bit, no PARITY state, format as in Operation.

## Test plan
- Reset, then a sync pulse, then word `1,0xA5 MSB-first,0` with PIX_W=8 → one `PAR_DATA_EN` with `PAR_DATA`=0xA5, `ROW_NUM`=0, `COL_NUM`=0, exactly one cycle after the stop bit.
- Full frame with COLS=4, ROWS=3, pixel values 0..11 and random `SER_INPUT_EN` gaps → 12 strobes in raster order, values matching. Columns wrap 3→0 with the row incrementing; `FRAME_DONE` exactly once, one cycle after pixel 11; `FRAME_ACTIVE` falls at the same time.
- Stop bit of word 2 forced to `1` → `ERROR` and `DEC_RSYNC` pulse together; no pixel for word 2; `FRAME_ACTIVE`=0. Later bits are ignored until the next sync.
- Sync pulse mid-frame after 5 pixels → no `ERROR`/`FRAME_DONE`; next pixel reports row 0, col 0. Sync coincident with a valid `1` bit → that bit is not taken as a start bit.
- `RESET` asserted during DATA of pixel 7 → all outputs are 0 within the same cycle. After release plus a sync, the first pixel reports position (0,0).
- With `RX_DESER_PARITY_EN`, word 0x03 with parity 0 → accepted. Word 0x07 with parity 0 → `ERROR` and `DEC_RSYNC` pulse; no pixel.
